// File: rtl/max7219_frame_rx.sv
// MAX7219 serial frame receiver.
// Oversamples the asynchronous din/ncs/sclk pins with the system clock, assembles
// 16-bit frames (MSB first) between ncs falling and rising edges, and applies
// accepted frames to a MAX7219-style register file. Frames that do not carry exactly
// 16 bits are rejected with a one-cycle error pulse and leave all state untouched.
module max7219_frame_rx #(
    parameter int DATAWIDTH_BUS = 8,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                     max7219_frame_rx_CLOCK_50,
    input  logic                     max7219_frame_rx_RESET_InHigh,
    input  logic                     max7219_frame_rx_din_In,
    input  logic                     max7219_frame_rx_ncs_In,
    input  logic                     max7219_frame_rx_sclk_In,
    input  logic [2:0]               max7219_frame_rx_rdAddr_In,
    output logic [DATAWIDTH_BUS-1:0] max7219_frame_rx_rdData_Out,
    output logic [3:0]               max7219_frame_rx_intensity_Out,
    output logic [2:0]               max7219_frame_rx_scanLimit_Out,
    output logic [7:0]               max7219_frame_rx_decodeMode_Out,
    output logic                     max7219_frame_rx_shutdownN_Out,
    output logic                     max7219_frame_rx_displayTest_Out,
    output logic                     max7219_frame_rx_frameValid_Out,
    output logic [3:0]               max7219_frame_rx_frameAddr_Out,
    output logic [7:0]               max7219_frame_rx_frameData_Out,
    output logic                     max7219_frame_rx_frameError_Out
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    localparam logic [4:0] BITS_PER_FRAME = 5'd16;
    localparam logic [4:0] BIT_CNT_MAX    = 5'd17;

    // Bit counter increment that sticks at 17 so any overlong frame stays "not 16".
    function automatic logic [4:0] sat_inc(input logic [4:0] cnt);
        sat_inc = (cnt >= BIT_CNT_MAX) ? BIT_CNT_MAX : cnt + 5'd1;
    endfunction

    // Synchronizer chains: index 0 is the pin-facing flop, SYNC_STAGES-1 the safe output.
    logic [SYNC_STAGES-1:0] din_sync_q,  din_sync_d;
    logic [SYNC_STAGES-1:0] ncs_sync_q,  ncs_sync_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;

    // History flops: previous synchronized value, used for edge detection. din_hist
    // is the data bit aligned with the sclk edge that sclk_rise reports.
    logic din_hist_q,  din_hist_d;
    logic ncs_hist_q,  ncs_hist_d;
    logic sclk_hist_q, sclk_hist_d;

    // Registered edge strobes.
    logic sclk_rise_q, sclk_rise_d;
    logic ncs_rise_q,  ncs_rise_d;
    logic ncs_fall_q,  ncs_fall_d;

    // Frame assembly.
    state_t      state_q, state_d;
    logic [15:0] shift_q, shift_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic        fall_pend_q, fall_pend_d;

    // Register file and frame report outputs.
    logic [DATAWIDTH_BUS-1:0] digit_q [8];
    logic [DATAWIDTH_BUS-1:0] digit_d [8];
    logic [7:0] decode_mode_q,  decode_mode_d;
    logic [3:0] intensity_q,    intensity_d;
    logic [2:0] scan_limit_q,   scan_limit_d;
    logic       shutdown_n_q,   shutdown_n_d;
    logic       display_test_q, display_test_d;
    logic [3:0] frame_addr_q,   frame_addr_d;
    logic [7:0] frame_data_q,   frame_data_d;
    logic       frame_valid_q,  frame_valid_d;
    logic       frame_error_q,  frame_error_d;

    // Command fields of the assembled frame; the top nibble carries no meaning.
    logic [3:0] cmd_addr;
    logic [7:0] cmd_data;
    logic       unused_cmd_hi;

    assign cmd_addr      = shift_q[11:8];
    assign cmd_data      = shift_q[7:0];
    assign unused_cmd_hi = ^shift_q[15:12];

    // Pin synchronization, history capture and edge strobe generation.
    always_comb begin
        din_sync_d  = {din_sync_q[SYNC_STAGES-2:0],  max7219_frame_rx_din_In};
        ncs_sync_d  = {ncs_sync_q[SYNC_STAGES-2:0],  max7219_frame_rx_ncs_In};
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], max7219_frame_rx_sclk_In};

        din_hist_d  = din_sync_q[SYNC_STAGES-1];
        ncs_hist_d  = ncs_sync_q[SYNC_STAGES-1];
        sclk_hist_d = sclk_sync_q[SYNC_STAGES-1];

        sclk_rise_d =  sclk_sync_q[SYNC_STAGES-1] & ~sclk_hist_q;
        ncs_rise_d  =  ncs_sync_q[SYNC_STAGES-1]  & ~ncs_hist_q;
        ncs_fall_d  = ~ncs_sync_q[SYNC_STAGES-1]  &  ncs_hist_q;
    end

    // Frame FSM, shifter and register-file update.
    always_comb begin
        state_d        = state_q;
        shift_d        = shift_q;
        bit_cnt_d      = bit_cnt_q;
        fall_pend_d    = fall_pend_q;
        digit_d        = digit_q;
        decode_mode_d  = decode_mode_q;
        intensity_d    = intensity_q;
        scan_limit_d   = scan_limit_q;
        shutdown_n_d   = shutdown_n_q;
        display_test_d = display_test_q;
        frame_addr_d   = frame_addr_q;
        frame_data_d   = frame_data_q;
        frame_valid_d  = 1'b0;
        frame_error_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A chip-select fall seen while committing counts only if ncs is
                // still low now; otherwise it was a glitch and is dropped.
                fall_pend_d = 1'b0;
                if (ncs_fall_q || (fall_pend_q && !ncs_hist_q)) begin
                    state_d   = ST_SHIFT;
                    bit_cnt_d = 5'd0;
                end
            end

            ST_SHIFT: begin
                // An sclk edge coinciding with the ncs release is not part of the frame.
                if (ncs_rise_q) begin
                    state_d = ST_COMMIT;
                end else if (sclk_rise_q) begin
                    shift_d   = {shift_q[14:0], din_hist_q};
                    bit_cnt_d = sat_inc(bit_cnt_q);
                end
            end

            ST_COMMIT: begin
                state_d     = ST_IDLE;
                fall_pend_d = ncs_fall_q;
                if (bit_cnt_q == BITS_PER_FRAME) begin
                    frame_valid_d = 1'b1;
                    frame_addr_d  = cmd_addr;
                    frame_data_d  = cmd_data;
                    case (cmd_addr)
                        4'h1, 4'h2, 4'h3, 4'h4,
                        4'h5, 4'h6, 4'h7, 4'h8: digit_d[3'(cmd_addr - 4'd1)] = DATAWIDTH_BUS'(cmd_data);
                        4'h9:    decode_mode_d  = cmd_data;
                        4'hA:    intensity_d    = cmd_data[3:0];
                        4'hB:    scan_limit_d   = cmd_data[2:0];
                        4'hC:    shutdown_n_d   = cmd_data[0];
                        4'hF:    display_test_d = cmd_data[0];
                        default: ; // 0x0 no-op, 0xD/0xE unmapped
                    endcase
                end else begin
                    frame_error_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset returns everything to the idle, cleared condition.
    always_ff @(posedge max7219_frame_rx_CLOCK_50 or posedge max7219_frame_rx_RESET_InHigh) begin
        if (max7219_frame_rx_RESET_InHigh) begin
            din_sync_q     <= '0;
            ncs_sync_q     <= '0;
            sclk_sync_q    <= '0;
            din_hist_q     <= 1'b0;
            ncs_hist_q     <= 1'b0;
            sclk_hist_q    <= 1'b0;
            sclk_rise_q    <= 1'b0;
            ncs_rise_q     <= 1'b0;
            ncs_fall_q     <= 1'b0;
            state_q        <= ST_IDLE;
            shift_q        <= '0;
            bit_cnt_q      <= '0;
            fall_pend_q    <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                digit_q[i] <= '0;
            end
            decode_mode_q  <= '0;
            intensity_q    <= '0;
            scan_limit_q   <= '0;
            shutdown_n_q   <= 1'b0;
            display_test_q <= 1'b0;
            frame_addr_q   <= '0;
            frame_data_q   <= '0;
            frame_valid_q  <= 1'b0;
            frame_error_q  <= 1'b0;
        end else begin
            din_sync_q     <= din_sync_d;
            ncs_sync_q     <= ncs_sync_d;
            sclk_sync_q    <= sclk_sync_d;
            din_hist_q     <= din_hist_d;
            ncs_hist_q     <= ncs_hist_d;
            sclk_hist_q    <= sclk_hist_d;
            sclk_rise_q    <= sclk_rise_d;
            ncs_rise_q     <= ncs_rise_d;
            ncs_fall_q     <= ncs_fall_d;
            state_q        <= state_d;
            shift_q        <= shift_d;
            bit_cnt_q      <= bit_cnt_d;
            fall_pend_q    <= fall_pend_d;
            digit_q        <= digit_d;
            decode_mode_q  <= decode_mode_d;
            intensity_q    <= intensity_d;
            scan_limit_q   <= scan_limit_d;
            shutdown_n_q   <= shutdown_n_d;
            display_test_q <= display_test_d;
            frame_addr_q   <= frame_addr_d;
            frame_data_q   <= frame_data_d;
            frame_valid_q  <= frame_valid_d;
            frame_error_q  <= frame_error_d;
        end
    end

    assign max7219_frame_rx_rdData_Out      = digit_q[max7219_frame_rx_rdAddr_In];
    assign max7219_frame_rx_intensity_Out   = intensity_q;
    assign max7219_frame_rx_scanLimit_Out   = scan_limit_q;
    assign max7219_frame_rx_decodeMode_Out  = decode_mode_q;
    assign max7219_frame_rx_shutdownN_Out   = shutdown_n_q;
    assign max7219_frame_rx_displayTest_Out = display_test_q;
    assign max7219_frame_rx_frameValid_Out  = frame_valid_q;
    assign max7219_frame_rx_frameAddr_Out   = frame_addr_q;
    assign max7219_frame_rx_frameData_Out   = frame_data_q;
    assign max7219_frame_rx_frameError_Out  = frame_error_q;

endmodule

// File: tb/tb_max7219_frame_rx.sv
// Bench for max7219_frame_rx: directed frames plus randomized frames and timing,
// checked against a register-level model of the MAX7219 command set.
module tb_max7219_frame_rx;

    localparam int DW = 8;
    localparam int S  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          din;
    logic          ncs;
    logic          sclk;
    logic [2:0]    rd_addr;
    logic [DW-1:0] rd_data;
    logic [3:0]    intensity;
    logic [2:0]    scan_limit;
    logic [7:0]    decode_mode;
    logic          shutdown_n;
    logic          display_test;
    logic          frame_valid;
    logic [3:0]    frame_addr;
    logic [7:0]    frame_data;
    logic          frame_error;

    max7219_frame_rx #(.DATAWIDTH_BUS(DW), .SYNC_STAGES(S)) dut (
        .max7219_frame_rx_CLOCK_50        (clk),
        .max7219_frame_rx_RESET_InHigh    (rst),
        .max7219_frame_rx_din_In          (din),
        .max7219_frame_rx_ncs_In          (ncs),
        .max7219_frame_rx_sclk_In         (sclk),
        .max7219_frame_rx_rdAddr_In       (rd_addr),
        .max7219_frame_rx_rdData_Out      (rd_data),
        .max7219_frame_rx_intensity_Out   (intensity),
        .max7219_frame_rx_scanLimit_Out   (scan_limit),
        .max7219_frame_rx_decodeMode_Out  (decode_mode),
        .max7219_frame_rx_shutdownN_Out   (shutdown_n),
        .max7219_frame_rx_displayTest_Out (display_test),
        .max7219_frame_rx_frameValid_Out  (frame_valid),
        .max7219_frame_rx_frameAddr_Out   (frame_addr),
        .max7219_frame_rx_frameData_Out   (frame_data),
        .max7219_frame_rx_frameError_Out  (frame_error)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: the visible register file of the display driver.
    logic [7:0]  m_digit [8];
    logic [7:0]  m_decode;
    logic [3:0]  m_int;
    logic [2:0]  m_scan;
    logic        m_shdn;
    logic        m_test;
    logic [3:0]  m_faddr;
    logic [7:0]  m_fdata;
    logic [15:0] exp_q [$];
    int          exp_valid = 0;
    int          exp_err   = 0;
    int          obs_valid = 0;
    int          obs_err   = 0;
    int          cyc       = 0;
    int          rise_mark = -1000;
    logic        prev_v    = 1'b0;
    logic        prev_e    = 1'b0;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_digit[i] = 8'h00;
        m_decode = 8'h00;
        m_int    = 4'h0;
        m_scan   = 3'h0;
        m_shdn   = 1'b0;
        m_test   = 1'b0;
        m_faddr  = 4'h0;
        m_fdata  = 8'h00;
    endtask

    task automatic model_apply(input logic [15:0] word);
        int a;
        a       = int'(word[11:8]);
        m_faddr = word[11:8];
        m_fdata = word[7:0];
        if (a >= 1 && a <= 8) m_digit[a-1] = word[7:0];
        else if (a == 9)      m_decode = word[7:0];
        else if (a == 10)     m_int    = word[3:0];
        else if (a == 11)     m_scan   = word[2:0];
        else if (a == 12)     m_shdn   = word[0];
        else if (a == 15)     m_test   = word[0];
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: latency from ncs release, pulse width and frame contents.
    always @(negedge clk) begin
        if (frame_valid === 1'b1) begin
            obs_valid <= obs_valid + 1;
            chk("valid_latency", 32'(cyc - rise_mark), 32'(S + 2));
            chk("valid_width", 32'(prev_v), 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
                chk("frame_addr", 32'(frame_addr), 32'(exp_q[0][11:8]));
                chk("frame_data", 32'(frame_data), 32'(exp_q[0][7:0]));
                void'(exp_q.pop_front());
            end
        end
        if (frame_error === 1'b1) begin
            obs_err <= obs_err + 1;
            chk("error_latency", 32'(cyc - rise_mark), 32'(S + 2));
            chk("error_width", 32'(prev_e), 32'd0);
        end
        prev_v <= frame_valid;
        prev_e <= frame_error;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Sends nbits serial bits (word MSB first, random filler past 16) and releases ncs.
    task automatic send_frame(input logic [15:0] word, input int nbits, input int gap);
        int ph;
        ph   = int'($urandom_range(S + 3, S + 1));
        ncs  = 1'b0;
        sclk = 1'b0;
        wait_clks(ph);
        for (int i = 0; i < nbits; i++) begin
            din = (i < 16) ? word[15 - i] : 1'($urandom);
            wait_clks(ph);
            sclk = 1'b1;
            wait_clks(ph);
            sclk = 1'b0;
        end
        wait_clks(ph);
        if (nbits == 16) begin
            exp_q.push_back(word);
            model_apply(word);
            exp_valid++;
        end else begin
            exp_err++;
        end
        rise_mark = cyc + 1;
        ncs = 1'b1;
        wait_clks(gap);
    endtask

    // Starts a frame and hits reset after nbits bits; the frame must vanish.
    task automatic abort_frame(input logic [15:0] word, input int nbits);
        ncs  = 1'b0;
        sclk = 1'b0;
        wait_clks(S + 2);
        for (int i = 0; i < nbits; i++) begin
            din = word[15 - i];
            wait_clks(S + 2);
            sclk = 1'b1;
            wait_clks(S + 2);
            sclk = 1'b0;
        end
        wait_clks(2);
        rst = 1'b1;
        model_reset();
        exp_valid = 0;
        exp_err   = 0;
        wait_clks(3);
        obs_valid = 0;
        obs_err   = 0;
        rst = 1'b0;
        wait_clks(S + 3);
        rise_mark = cyc + 1;
        ncs = 1'b1;
        wait_clks(S + 6);
    endtask

    task automatic check_regs(input string where);
        wait_clks(S + 4);
        for (int a = 0; a < 8; a++) begin
            rd_addr = 3'(a);
            #1;
            chk($sformatf("%s_digit%0d", where, a), 32'(rd_data), 32'(m_digit[a]));
        end
        chk({where, "_decode"},    32'(decode_mode),  32'(m_decode));
        chk({where, "_intensity"}, 32'(intensity),    32'(m_int));
        chk({where, "_scan"},      32'(scan_limit),   32'(m_scan));
        chk({where, "_shdn"},      32'(shutdown_n),   32'(m_shdn));
        chk({where, "_test"},      32'(display_test), 32'(m_test));
        chk({where, "_faddr"},     32'(frame_addr),   32'(m_faddr));
        chk({where, "_fdata"},     32'(frame_data),   32'(m_fdata));
        chk({where, "_nvalid"},    32'(obs_valid),    32'(exp_valid));
        chk({where, "_nerror"},    32'(obs_err),      32'(exp_err));
        chk({where, "_pending"},   32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [15:0] w;
        int          nb;
        rst     = 1'b1;
        din     = 1'b0;
        ncs     = 1'b1;
        sclk    = 1'b0;
        rd_addr = 3'd0;
        model_reset();
        wait_clks(3);
        chk("reset_valid", 32'(frame_valid), 32'd0);
        chk("reset_error", 32'(frame_error), 32'd0);
        rst = 1'b0;
        check_regs("reset");

        send_frame(16'h0A0A, 16, S + 6);
        check_regs("intensity");

        send_frame(16'h01FF, 16, S + 6);
        send_frame(16'h0855, 16, S + 6);
        check_regs("digits");

        send_frame(16'h0B03, 15, S + 6);
        send_frame(16'h0B03, 17, S + 6);
        send_frame(16'h0B03, 0,  S + 6);
        send_frame(16'h0B03, 20, S + 6);
        check_regs("badlen");

        send_frame(16'h0C01, 16, S + 6);
        send_frame(16'h0F01, 16, S + 6);
        send_frame(16'h0000, 16, S + 6);
        check_regs("shdn_test");

        abort_frame(16'h0B07, 9);
        check_regs("aborted");
        send_frame(16'h0B07, 16, S + 6);
        check_regs("scan");

        send_frame(16'h0203, 16, S + 1);
        send_frame(16'h0304, 16, S + 6);
        check_regs("b2b");

        for (int k = 0; k < 40; k++) begin
            w  = 16'($urandom);
            nb = ($urandom_range(5, 0) == 0) ? int'($urandom_range(18, 13)) : 16;
            send_frame(w, nb, int'($urandom_range(S + 6, S + 1)));
            if (k % 8 == 7) check_regs($sformatf("rand%0d", k));
        end
        check_regs("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
